// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state encoding and owner codes for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-request round-robin selector; grant is one-hot, last = 1 means m1 won previously.
module rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? OWNER_M0 : OWNER_M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one ROM/RAM bus between two masters.
// Optional memory timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              rom_read,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-2:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner,
  output logic              rom_wr_err,
  output logic              timeout_err
);

  localparam int unsigned SEL = ADDR_W - 1;

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rom_rd_q, rom_rd_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_rdy_q, m0_rdy_d;
  logic              m1_rdy_q, m1_rdy_d;
  logic              rom_err_q, rom_err_d;

  logic [1:0]        req_c;
  logic [1:0]        grant_c;
  logic              rom_write_c;
  logic [DATA_W-1:0] rd_sel_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_err_q, to_err_d;
  logic              to_hit_c;
  // Limit is hit on the last BUSY cycle the counter allows without mem_ready.
  assign to_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic              unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign req_c       = {m1_read | m1_write, m0_read | m0_write};
  assign rom_write_c = wr_q & ~addr_q[SEL];
  assign rd_sel_c    = addr_q[SEL] ? ram_rdata : rom_rdata;

  rr_pick2 u_pick (
    .req   (req_c),
    .last  (last_q),
    .grant (grant_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rom_rd_d   = rom_rd_q;
    ram_rd_d   = ram_rd_q;
    ram_wr_d   = ram_wr_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_rdy_d   = 1'b0;
    m1_rdy_d   = 1'b0;
    rom_err_d  = rom_err_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_err_d   = to_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_c != OWNER_NONE) begin
          owner_d = grant_c;
          if (grant_c[1]) begin
            addr_d  = m1_address;
            wdata_d = m1_wdata;
            wr_d    = m1_write;
          end else begin
            addr_d  = m0_address;
            wdata_d = m0_wdata;
            wr_d    = m0_write;
          end
          // A write into ROM space raises no strobe at all.
          rom_rd_d = ~addr_d[SEL] & ~wr_d;
          ram_rd_d =  addr_d[SEL] & ~wr_d;
          ram_wr_d =  addr_d[SEL] &  wr_d;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (rom_write_c) begin
          rom_err_d = 1'b1;
          state_d   = ST_RESP;
        end else if (mem_ready) begin
          if (!wr_q) begin
            if (owner_q[1]) m1_rdata_d = rd_sel_c;
            else            m0_rdata_d = rd_sel_c;
          end
          state_d = ST_RESP;
`ifdef ARB_TIMEOUT_EN
        end else if (to_hit_c) begin
          if (owner_q[1]) m1_rdata_d = '1;
          else            m0_rdata_d = '1;
          to_err_d = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end

        if (state_d == ST_RESP) begin
          rom_rd_d = 1'b0;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          m0_rdy_d = owner_q[0];
          m1_rdy_d = owner_q[1];
        end
      end

      ST_RESP: begin
        last_d  = owner_q[1];
        owner_d = OWNER_NONE;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      owner_q    <= OWNER_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rom_rd_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_rdy_q   <= 1'b0;
      m1_rdy_q   <= 1'b0;
      rom_err_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
      to_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rom_rd_q   <= rom_rd_d;
      ram_rd_q   <= ram_rd_d;
      ram_wr_q   <= ram_wr_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_rdy_q   <= m0_rdy_d;
      m1_rdy_q   <= m1_rdy_d;
      rom_err_q  <= rom_err_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      to_err_q   <= to_err_d;
`endif
    end
  end

  assign rom_read    = rom_rd_q;
  assign ram_read    = ram_rd_q;
  assign ram_write   = ram_wr_q;
  assign mem_address = addr_q[ADDR_W-2:0];
  assign mem_wdata   = wdata_q;
  assign owner       = owner_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign m0_ready    = m0_rdy_q;
  assign m1_ready    = m1_rdy_q;
  assign rom_wr_err  = rom_err_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized two-master traffic
// against a transaction-level model; honours ARB_TIMEOUT_EN like the design.
module tb_mem_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO = 3;
`else
  localparam int unsigned TO = 15;
`endif

  typedef struct {
    logic       wr;
    logic       rd_too;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  logic       clk;
  logic       reset;
  logic       m0_read, m0_write, m1_read, m1_write;
  logic [7:0] m0_address, m0_wdata, m0_rdata, m1_address, m1_wdata, m1_rdata;
  logic       m0_ready, m1_ready;
  logic       rom_read, ram_read, ram_write;
  logic [6:0] mem_address;
  logic [7:0] mem_wdata, rom_rdata, ram_rdata;
  logic       mem_ready;
  logic [1:0] owner;
  logic       rom_wr_err, timeout_err;

  int         n_checks;
  int         n_pass;
  int         mem_wait;
  logic       mem_never;
  int         age;
  logic [7:0] ram_mem [128];
  logic [7:0] ram_ref [128];

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .rom_read(rom_read), .ram_read(ram_read), .ram_write(ram_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .mem_ready(mem_ready),
    .owner(owner), .rom_wr_err(rom_wr_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [6:0] a);
    return {1'b0, a} ^ 8'h39;
  endfunction

  function automatic logic [7:0] ram_init(input int i);
    return 8'(i * 5 + 1);
  endfunction

  // Memory environment: acknowledges after mem_wait strobe cycles, RAM backed by an array.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age <= 0;
      for (int i = 0; i < 128; i++) ram_mem[i] <= ram_init(i);
    end else begin
      if (rom_read | ram_read | ram_write) age <= age + 1;
      else                                 age <= 0;
      if (ram_write && mem_ready) ram_mem[mem_address] <= mem_wdata;
    end
  end

  assign mem_ready = (rom_read | ram_read | ram_write) && !mem_never && (age >= mem_wait);
  assign rom_rdata = rom_f(mem_address);
  assign ram_rdata = ram_mem[mem_address];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = 8'h00; m0_wdata = 8'h00;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = 8'h00; m1_wdata = 8'h00;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_masters();
    mem_wait  = 0;
    mem_never = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 128; i++) ram_ref[i] = ram_init(i);
  endtask

  task automatic drive_op(input int m, input op_t op, input bit valid);
    if (m == 0) begin
      m0_write = valid & op.wr;  m0_read = valid & (~op.wr | op.rd_too);
      m0_address = op.addr;      m0_wdata = op.data;
    end else begin
      m1_write = valid & op.wr;  m1_read = valid & (~op.wr | op.rd_too);
      m1_address = op.addr;      m1_wdata = op.data;
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.wr     = ($urandom_range(0, 2) == 0);
    o.rd_too = 1'($urandom_range(0, 1));
    o.addr   = 8'($urandom);
    o.data   = 8'($urandom);
    return o;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    m0_read = 1'b1; m1_write = 1'b1; m0_address = 8'h85; m1_address = 8'h03;
    m0_wdata = 8'h00; m1_wdata = 8'h77; m0_write = 1'b0; m1_read = 1'b0;
    mem_wait = 0; mem_never = 1'b0;
    repeat (3) tick();
    n_checks++; if (owner !== 2'b00) $display("FAIL reset_owner: got %b expected 00", owner); else n_pass++;
    n_checks++; if ({rom_read, ram_read, ram_write} !== 3'b000) $display("FAIL reset_strobes: got %b expected 000", {rom_read, ram_read, ram_write}); else n_pass++;
    n_checks++; if ({m1_ready, m0_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {m1_ready, m0_ready}); else n_pass++;
    n_checks++; if ({m1_rdata, m0_rdata} !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", {m1_rdata, m0_rdata}); else n_pass++;
    n_checks++; if ({rom_wr_err, timeout_err} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {rom_wr_err, timeout_err}); else n_pass++;
    clear_masters();
    reset = 1'b1;
  endtask

  task automatic test_rom_read();
    apply_reset();
    m0_read = 1'b1; m0_address = 8'h05;
    tick();
    n_checks++; if (rom_read !== 1'b1) $display("FAIL romrd_strobe: got %b expected 1", rom_read); else n_pass++;
    n_checks++; if (mem_address !== 7'h05) $display("FAIL romrd_addr: got %h expected 05", mem_address); else n_pass++;
    n_checks++; if ({ram_read, ram_write, m0_ready} !== 3'b000) $display("FAIL romrd_busy_other: got %b expected 000", {ram_read, ram_write, m0_ready}); else n_pass++;
    n_checks++; if (owner !== 2'b01) $display("FAIL romrd_owner: got %b expected 01", owner); else n_pass++;
    tick();
    n_checks++; if ({m1_ready, m0_ready} !== 2'b01) $display("FAIL romrd_ready: got %b expected 01", {m1_ready, m0_ready}); else n_pass++;
    n_checks++; if (m0_rdata !== 8'h3C) $display("FAIL romrd_data: got %h expected 3c", m0_rdata); else n_pass++;
    n_checks++; if (rom_read !== 1'b0) $display("FAIL romrd_strobe_drop: got %b expected 0", rom_read); else n_pass++;
    m0_read = 1'b0;
    tick();
    n_checks++; if ({m0_ready, owner} !== 3'b000) $display("FAIL romrd_idle: got %b expected 000", {m0_ready, owner}); else n_pass++;
  endtask

  task automatic test_ram_both();
    apply_reset();
    m0_write = 1'b1; m0_address = 8'h80; m0_wdata = 8'h11;
    m1_write = 1'b1; m1_address = 8'h81; m1_wdata = 8'h22;
    tick();
    n_checks++; if ({ram_write, mem_address, mem_wdata, owner} !== {1'b1, 7'h00, 8'h11, 2'b01}) $display("FAIL both_first: got wr=%b a=%h d=%h own=%b expected 1/00/11/01", ram_write, mem_address, mem_wdata, owner); else n_pass++;
    tick();
    n_checks++; if ({m1_ready, m0_ready} !== 2'b01) $display("FAIL both_ready0: got %b expected 01", {m1_ready, m0_ready}); else n_pass++;
    m0_write = 1'b0;
    tick();
    tick();
    n_checks++; if ({ram_write, mem_address, mem_wdata, owner} !== {1'b1, 7'h01, 8'h22, 2'b10}) $display("FAIL both_second: got wr=%b a=%h d=%h own=%b expected 1/01/22/10", ram_write, mem_address, mem_wdata, owner); else n_pass++;
    tick();
    n_checks++; if ({m1_ready, m0_ready} !== 2'b10) $display("FAIL both_ready1: got %b expected 10", {m1_ready, m0_ready}); else n_pass++;
    m1_write = 1'b0;
    tick();
    n_checks++; if ({ram_mem[0], ram_mem[1]} !== 16'h1122) $display("FAIL both_mem: got %h expected 1122", {ram_mem[0], ram_mem[1]}); else n_pass++;
  endtask

  task automatic test_rom_write();
    m1_write = 1'b1; m1_address = 8'h10; m1_wdata = 8'h5A;
    tick();
    n_checks++; if ({rom_read, ram_read, ram_write} !== 3'b000) $display("FAIL romwr_strobes: got %b expected 000", {rom_read, ram_read, ram_write}); else n_pass++;
    n_checks++; if (owner !== 2'b10) $display("FAIL romwr_owner: got %b expected 10", owner); else n_pass++;
    tick();
    n_checks++; if ({m1_ready, m0_ready} !== 2'b10) $display("FAIL romwr_ready: got %b expected 10", {m1_ready, m0_ready}); else n_pass++;
    n_checks++; if (rom_wr_err !== 1'b1) $display("FAIL romwr_flag: got %b expected 1", rom_wr_err); else n_pass++;
    n_checks++; if (m1_rdata !== 8'h00) $display("FAIL romwr_rdata: got %h expected 00", m1_rdata); else n_pass++;
    m1_write = 1'b0;
    repeat (3) tick();
    n_checks++; if (rom_wr_err !== 1'b1) $display("FAIL romwr_sticky: got %b expected 1", rom_wr_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int late_rdy;
    mem_wait = 4;
    m1_read = 1'b1; m1_address = 8'h90;
    tick();
    n_checks++; if ({ram_read, mem_address} !== {1'b1, 7'h10}) $display("FAIL mid_strobe: got rd=%b a=%h expected 1/10", ram_read, mem_address); else n_pass++;
    tick();
    n_checks++; if ({ram_read, m1_ready} !== 2'b10) $display("FAIL mid_busy2: got %b expected 10", {ram_read, m1_ready}); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if ({rom_read, ram_read, ram_write} !== 3'b000) $display("FAIL mid_drop: got %b expected 000", {rom_read, ram_read, ram_write}); else n_pass++;
    n_checks++; if ({owner, m1_ready} !== 3'b000) $display("FAIL mid_owner: got %b expected 000", {owner, m1_ready}); else n_pass++;
    n_checks++; if ({rom_wr_err, timeout_err} !== 2'b00) $display("FAIL mid_flags: got %b expected 00", {rom_wr_err, timeout_err}); else n_pass++;
    m1_read = 1'b0;
    tick();
    reset = 1'b1;
    late_rdy = 0;
    repeat (8) begin
      tick();
      if (m1_ready | m0_ready) late_rdy++;
    end
    n_checks++; if (late_rdy !== 0) $display("FAIL mid_lost: got %0d ready pulses expected 0", late_rdy); else n_pass++;
    mem_wait = 0;
  endtask

  task automatic test_timeout();
    int  rd_cycles;
    bit  got;
    apply_reset();
`ifdef ARB_TIMEOUT_EN
    mem_never = 1'b1;
    m0_read = 1'b1; m0_address = 8'hA0;
    rd_cycles = 0; got = 0;
    for (int c = 0; c < int'(TO) + 10 && !got; c++) begin
      tick();
      if (ram_read) rd_cycles++;
      if (m0_ready) got = 1;
    end
    n_checks++; if (!got) $display("FAIL to_ready: got none expected m0_ready"); else n_pass++;
    n_checks++; if (rd_cycles !== int'(TO)) $display("FAIL to_strobe_len: got %0d expected %0d", rd_cycles, TO); else n_pass++;
    n_checks++; if (m0_rdata !== 8'hFF) $display("FAIL to_data: got %h expected ff", m0_rdata); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_flag: got %b expected 1", timeout_err); else n_pass++;
    m0_read = 1'b0;
    tick();
    // Acknowledge lands on the same cycle as the limit: data must win.
    mem_never = 1'b0; mem_wait = int'(TO) - 1;
    m0_read = 1'b1; m0_address = 8'hA1;
    rd_cycles = 0; got = 0;
    for (int c = 0; c < int'(TO) + 10 && !got; c++) begin
      tick();
      if (ram_read) rd_cycles++;
      if (m0_ready) got = 1;
    end
    n_checks++; if (!got || rd_cycles !== int'(TO)) $display("FAIL to_edge_len: got %0d (ready %0d) expected %0d", rd_cycles, got, TO); else n_pass++;
    n_checks++; if (m0_rdata !== ram_ref[7'h21]) $display("FAIL to_edge_data: got %h expected %h", m0_rdata, ram_ref[7'h21]); else n_pass++;
`else
    mem_never = 1'b1;
    m0_read = 1'b1; m0_address = 8'hA0;
    got = 0; rd_cycles = 0;
    repeat (30) begin
      tick();
      if (m0_ready) got = 1;
      if (ram_read) rd_cycles++;
    end
    n_checks++; if (got || rd_cycles !== 30) $display("FAIL wait_hold: got ready=%0d strobe_cycles=%0d expected 0/30", got, rd_cycles); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL wait_flag: got %b expected 0", timeout_err); else n_pass++;
    mem_never = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (m0_ready) got = 1;
    end
    n_checks++; if (!got) $display("FAIL wait_release: got none expected m0_ready"); else n_pass++;
    n_checks++; if (m0_rdata !== ram_ref[7'h20]) $display("FAIL wait_data: got %h expected %h", m0_rdata, ram_ref[7'h20]); else n_pass++;
`endif
    m0_read = 1'b0;
    mem_wait = 0;
    tick();
  endtask

  task automatic test_traffic();
    op_t        q0[$];
    op_t        q1[$];
    op_t        op;
    logic [7:0] exp_rd[2];
    logic [2:0] exp_strb, seen_strb;
    logic [1:0] exp_own, seen_own, rdy;
    logic [6:0] seen_a;
    logic [7:0] seen_wd;
    int         last_g, pick;
    bit         exp_rom_err, done, both;

    apply_reset();
    for (int i = 0; i < 12; i++) q0.push_back(rand_op());
    for (int i = 0; i < 7; i++)  q1.push_back(rand_op());
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    last_g = 1; exp_rom_err = 0;
    drive_op(0, q0[0], 1'b1);
    drive_op(1, q1[0], 1'b1);

    while (q0.size() + q1.size() > 0) begin
      // The master not served last wins whenever both are waiting.
      if (q0.size() > 0 && q1.size() > 0) pick = 1 - last_g;
      else                                pick = (q0.size() > 0) ? 0 : 1;
      op = (pick == 1) ? q1[0] : q0[0];
      exp_own = (pick == 1) ? 2'b10 : 2'b01;
      if (!op.wr)          exp_rd[pick] = op.addr[7] ? ram_ref[op.addr[6:0]] : rom_f(op.addr[6:0]);
      else if (op.addr[7]) ram_ref[op.addr[6:0]] = op.data;
      else                 exp_rom_err = 1;
      exp_strb = op.wr ? (op.addr[7] ? 3'b001 : 3'b000) : (op.addr[7] ? 3'b010 : 3'b100);

      mem_wait = $urandom_range(0, 2);
      done = 0; both = 0; seen_strb = 3'b000; seen_own = 2'b00; rdy = 2'b00;
      seen_a = 7'h00; seen_wd = 8'h00;
      for (int c = 0; c < 40 && !done; c++) begin
        tick();
        if (m0_ready && m1_ready) both = 1;
        if (owner != 2'b00) seen_own = owner;
        if (rom_read | ram_read | ram_write) begin
          seen_strb = seen_strb | {rom_read, ram_read, ram_write};
          seen_a    = mem_address;
          seen_wd   = mem_wdata;
        end
        if (m0_ready | m1_ready) begin
          done = 1;
          rdy  = {m1_ready, m0_ready};
        end
      end

      n_checks++;
      if (!done) begin
        $display("FAIL traffic_hang: got no ready within 40 cycles expected master %0d", pick);
        break;
      end
      n_pass++;
      n_checks++; if (rdy !== exp_own) $display("FAIL traffic_grant: got %b expected %b", rdy, exp_own); else n_pass++;
      n_checks++; if (seen_own !== exp_own) $display("FAIL traffic_owner: got %b expected %b", seen_own, exp_own); else n_pass++;
      n_checks++; if (both !== 1'b0) $display("FAIL traffic_dual_ready: got %b expected 0", both); else n_pass++;
      n_checks++; if (seen_strb !== exp_strb) $display("FAIL traffic_strobe: got %b expected %b", seen_strb, exp_strb); else n_pass++;
      if (exp_strb != 3'b000) begin
        n_checks++; if (seen_a !== op.addr[6:0]) $display("FAIL traffic_addr: got %h expected %h", seen_a, op.addr[6:0]); else n_pass++;
      end
      if (exp_strb == 3'b001) begin
        n_checks++; if (seen_wd !== op.data) $display("FAIL traffic_wdata: got %h expected %h", seen_wd, op.data); else n_pass++;
      end
      n_checks++; if ({m1_rdata, m0_rdata} !== {exp_rd[1], exp_rd[0]}) $display("FAIL traffic_rdata: got %h expected %h", {m1_rdata, m0_rdata}, {exp_rd[1], exp_rd[0]}); else n_pass++;

      last_g = pick;
      if (pick == 0) begin
        q0.delete(0);
        if (q0.size() > 0) drive_op(0, q0[0], 1'b1); else drive_op(0, op, 1'b0);
      end else begin
        q1.delete(0);
        if (q1.size() > 0) drive_op(1, q1[0], 1'b1); else drive_op(1, op, 1'b0);
      end
    end

    clear_masters();
    tick();
    n_checks++; if (rom_wr_err !== exp_rom_err) $display("FAIL traffic_romerr: got %b expected %b", rom_wr_err, exp_rom_err); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL traffic_toerr: got %b expected 0", timeout_err); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    clear_masters();
    mem_wait  = 0;
    mem_never = 1'b0;
    test_reset();
    test_rom_read();
    test_ram_both();
    test_rom_write();
    test_reset_mid();
    test_timeout();
    test_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
